breakout_ball_engine: RTL

- Game-logic engine on the far side of the breakout game-state FSM interface. It consumes `game_state` and `game_reset`, and produces `lose_sig` and `win_sig` for the FSM.
- Once per frame tick it moves the ball, reflects it off the walls and paddle, clears bricks and keeps score.
- It feeds ball position and the brick map to the VGA renderer.

---
 rtl/breakout_ball_engine.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/breakout_ball_engine.sv
// ---------------------------------------------------------------------------
// breakout_ball_engine
//
// Ball / brick / score engine for the breakout game. Once per accepted
// frame_tick it runs a three-step update (idle -> move -> collide):
// the ball is moved and wall-reflected, then tested against the brick
// field, the paddle and the floor. It reports win/lose pulses to the game
// FSM and exports the ball position and brick map for the renderer.
//
// Ports:
//   sys_clk     system clock
//   sys_rst     asynchronous active-high reset
//   frame_tick  one-cycle pulse per video frame
//   game_state  00 IDLE, 01 PLAY, 10 WIN, 11 END (updates only run in PLAY)
//   game_reset  one-cycle synchronous pulse; restarts the round
//   paddle_x    paddle left edge
//   ball_x      ball left edge
//   ball_y      ball top edge
//   brick_map   bit i = brick i alive, i = row*BRICK_COLS + col
//   score       bricks cleared
//   lose_sig    one-cycle pulse when the ball reaches the floor
//   win_sig     one-cycle pulse when the last brick is cleared
// ---------------------------------------------------------------------------
module breakout_ball_engine #(
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int SPEED      = 2,
  parameter int START_X    = 316,
  parameter int START_Y    = 400,
  parameter int PADDLE_Y   = 440,
  parameter int PADDLE_W   = 80,
  parameter int BRICK_TOP  = 32,
  parameter int BRICK_W    = 64,
  parameter int BRICK_H    = 16,
  parameter int BRICK_COLS = 10,
  parameter int BRICK_ROWS = 4
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             frame_tick,
  input  logic [1:0]                       game_state,
  input  logic                             game_reset,
  input  logic [9:0]                       paddle_x,
  output logic [9:0]                       ball_x,
  output logic [9:0]                       ball_y,
  output logic [BRICK_ROWS*BRICK_COLS-1:0] brick_map,
  output logic [7:0]                       score,
  output logic                             lose_sig,
  output logic                             win_sig
);

  localparam int N_BRICKS = BRICK_ROWS * BRICK_COLS;
  // Brick dimensions are powers of two, so row/col come from plain shifts.
  localparam int H_SHIFT  = $clog2(BRICK_H);
  localparam int W_SHIFT  = $clog2(BRICK_W);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_MOVE  = 2'd1;
  localparam logic [1:0] U_COLL  = 2'd2;
  localparam logic [1:0] GS_PLAY = 2'b01;

  logic [1:0]          state_reg;
  logic [9:0]          ball_x_reg;
  logic [9:0]          ball_y_reg;
  logic                dx_reg;        // 1 = moving right, 0 = moving left
  logic                dy_reg;        // 1 = moving down,  0 = moving up
  logic [N_BRICKS-1:0] brick_map_reg;
  logic [7:0]          score_reg;
  logic                lose_reg;
  logic                win_reg;
  logic                done_reg;

  // 11-bit copies so that "position + size" sums never wrap.
  logic [10:0] bx_ext;
  logic [10:0] by_ext;
  logic [10:0] pad_ext;

  assign bx_ext  = {1'b0, ball_x_reg};
  assign by_ext  = {1'b0, ball_y_reg};
  assign pad_ext = {1'b0, paddle_x};

  // -------------------------------------------------------------------------
  // Move step: next position and direction with wall reflection.
  // -------------------------------------------------------------------------
  logic [9:0] move_x_next;
  logic [9:0] move_y_next;
  logic       move_dx_next;
  logic       move_dy_next;

  always_comb begin
    move_x_next  = ball_x_reg;
    move_y_next  = ball_y_reg;
    move_dx_next = dx_reg;
    move_dy_next = dy_reg;

    if (!dx_reg && (ball_x_reg < 10'(SPEED))) begin
      move_x_next  = '0;
      move_dx_next = 1'b1;
    end else if (dx_reg && ((bx_ext + 11'(SPEED + BALL_SIZE)) > 11'(SCR_W))) begin
      move_x_next  = 10'(SCR_W - BALL_SIZE);
      move_dx_next = 1'b0;
    end else if (dx_reg) begin
      move_x_next  = ball_x_reg + 10'(SPEED);
    end else begin
      move_x_next  = ball_x_reg - 10'(SPEED);
    end

    // Only the top wall reflects; the bottom is handled as the floor rule.
    if (!dy_reg && (ball_y_reg < 10'(SPEED))) begin
      move_y_next  = '0;
      move_dy_next = 1'b1;
    end else if (dy_reg) begin
      move_y_next  = ball_y_reg + 10'(SPEED);
    end else begin
      move_y_next  = ball_y_reg - 10'(SPEED);
    end
  end

  // -------------------------------------------------------------------------
  // Collision step: evaluated on the already-moved position.
  // -------------------------------------------------------------------------
  logic [10:0]         cx;
  logic [10:0]         cy;
  logic [10:0]         row_idx;
  logic [10:0]         col_idx;
  logic                in_field;
  logic [N_BRICKS-1:0] hit_vec;
  logic [N_BRICKS-1:0] bricks_after_next;
  logic                brick_hit;
  logic                paddle_hit;
  logic                floor_hit;

  assign cx = bx_ext + 11'(BALL_SIZE / 2);
  assign cy = by_ext + 11'(BALL_SIZE / 2);

  assign in_field = (cy >= 11'(BRICK_TOP)) &&
                    (cy <  11'(BRICK_TOP + BRICK_ROWS * BRICK_H)) &&
                    (cx <  11'(BRICK_COLS * BRICK_W));

  // row_idx is only meaningful inside the field; in_field gates every use.
  assign row_idx = (cy - 11'(BRICK_TOP)) >> H_SHIFT;
  assign col_idx = cx >> W_SHIFT;

  // One-hot decode of the brick under the ball centre.
  genvar gi;
  generate
    for (gi = 0; gi < N_BRICKS; gi++) begin : g_hit
      assign hit_vec[gi] = in_field &&
                           (row_idx == 11'(gi / BRICK_COLS)) &&
                           (col_idx == 11'(gi % BRICK_COLS));
    end
  endgenerate

  assign brick_hit         = |(hit_vec & brick_map_reg);
  assign bricks_after_next = brick_map_reg & ~hit_vec;

  assign paddle_hit = dy_reg &&
                      ((by_ext + 11'(BALL_SIZE)) >= 11'(PADDLE_Y)) &&
                      (by_ext < 11'(PADDLE_Y)) &&
                      ((bx_ext + 11'(BALL_SIZE)) > pad_ext) &&
                      (bx_ext < (pad_ext + 11'(PADDLE_W)));

  assign floor_hit = (by_ext + 11'(BALL_SIZE)) >= 11'(SCR_H);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= U_IDLE;
      ball_x_reg    <= 10'(START_X);
      ball_y_reg    <= 10'(START_Y);
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b0;
      brick_map_reg <= '1;
      score_reg     <= '0;
      lose_reg      <= 1'b0;
      win_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      lose_reg <= 1'b0;
      win_reg  <= 1'b0;
      if (game_reset) begin
        // Aborts any update in flight.
        state_reg     <= U_IDLE;
        ball_x_reg    <= 10'(START_X);
        ball_y_reg    <= 10'(START_Y);
        dx_reg        <= 1'b1;
        dy_reg        <= 1'b0;
        brick_map_reg <= '1;
        score_reg     <= '0;
        done_reg      <= 1'b0;
      end else begin
        case (state_reg)
          U_IDLE: begin
            if (frame_tick && (game_state == GS_PLAY) && !done_reg) begin
              state_reg <= U_MOVE;
            end
          end
          U_MOVE: begin
            ball_x_reg <= move_x_next;
            ball_y_reg <= move_y_next;
            dx_reg     <= move_dx_next;
            dy_reg     <= move_dy_next;
            state_reg  <= U_COLL;
          end
          U_COLL: begin
            state_reg <= U_IDLE;
            if (brick_hit) begin
              brick_map_reg <= bricks_after_next;
              score_reg     <= score_reg + 8'd1;
              dy_reg        <= ~dy_reg;
              if (bricks_after_next == '0) begin
                win_reg  <= 1'b1;
                done_reg <= 1'b1;
              end
            end else if (paddle_hit) begin
              dy_reg     <= 1'b0;
              ball_y_reg <= 10'(PADDLE_Y - BALL_SIZE);
            end else if (floor_hit) begin
              lose_reg <= 1'b1;
              done_reg <= 1'b1;
            end
          end
          default: state_reg <= U_IDLE;
        endcase
      end
    end
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign brick_map = brick_map_reg;
  assign score     = score_reg;
  assign lose_sig  = lose_reg;
  assign win_sig   = win_reg;

endmodule
